// File: rtl/training_mem_loader.sv
// training_mem_loader: writer side of the training-data memory port.
// Labelled feature words arrive on a valid/ready stream and pass through a small
// FIFO. Each word is then written to consecutive addresses starting at 0.
// A memory word is {label, feature3, feature2, feature1, feature0}.
// Define LOADER_VERIFY_EN to read back and compare every word after it is written.
// In that build each word takes 4 cycles instead of 2, and any mismatch sets a
// sticky verify_err flag.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no session; the memory port is released (cs/we/oe low)
// S_POP   | wait for a buffered word, move the FIFO head into mem_wdata
// S_WRITE | cs=1 we=1 for one cycle at mem_address
// S_RD    | readback cycle, cs=1 oe=1 (verify build only)
// S_CMP   | compare mem_rdata with the written word (verify build only)
// S_DONE  | one-cycle load_done pulse, then back to idle
module training_mem_loader #(
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_SAMPLES = 256
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        load_start,
    input  logic [8:0]  load_len,
    input  logic        load_abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_label,
    output logic [7:0]  mem_address,
    output logic [32:0] mem_wdata,
    input  logic [32:0] mem_rdata,
    output logic        cs_control,
    output logic        we_control,
    output logic        oe_control,
    output logic        load_busy,
    output logic        load_done,
    output logic [8:0]  loaded_count,
    output logic        verify_err
);

    localparam int             PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]    DEPTH_CNT = FIFO_DEPTH[PW:0];
    localparam logic [8:0]     MAX_LEN   = 9'(MAX_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WRITE,
        S_RD,
        S_CMP,
        S_DONE
    } state_t;

    state_t        state;
    logic [32:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   fifo_cnt;
    logic [8:0]    len_reg;
    logic [8:0]    accepted;
    logic [8:0]    len_clamped;
    logic [7:0]    next_addr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          flush;

    assign fifo_full   = (fifo_cnt == DEPTH_CNT);
    assign fifo_empty  = (fifo_cnt == '0);
    assign in_ready    = load_busy && !fifo_full && (accepted < len_reg);
    assign flush       = load_abort && (state != S_IDLE);
    // A word offered in the abort cycle is flushed together with the rest.
    assign push        = in_valid && in_ready && !flush;
    assign pop         = (state == S_POP) && !fifo_empty && !load_abort;
    assign len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    // The address saturates at the top word, so a full-capacity load never wraps to 0.
    assign next_addr   = (mem_address == 8'hFF) ? mem_address : mem_address + 8'd1;

`ifndef LOADER_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign verify_err   = 1'b0;
`endif

    // FIFO storage; contents are don't-care until written, so no reset is needed
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_label, in_data};
        end
    end

    // FIFO pointers and occupancy; a push and a pop in the same cycle leave the count unchanged
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Session FSM with registered memory strobes, counters and status
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state        <= S_IDLE;
            mem_address  <= '0;
            mem_wdata    <= '0;
            cs_control   <= 1'b0;
            we_control   <= 1'b0;
            oe_control   <= 1'b0;
            load_busy    <= 1'b0;
            load_done    <= 1'b0;
            loaded_count <= '0;
            len_reg      <= '0;
            accepted     <= '0;
`ifdef LOADER_VERIFY_EN
            verify_err   <= 1'b0;
`endif
        end else begin
            load_done <= 1'b0;
            if (push) accepted <= accepted + 9'd1;

            if (flush) begin
                // A write on its final cycle still lands in memory, so it is counted.
                if (state == S_WRITE) loaded_count <= loaded_count + 9'd1;
                state      <= S_IDLE;
                load_busy  <= 1'b0;
                cs_control <= 1'b0;
                we_control <= 1'b0;
                oe_control <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (load_start) begin
                            mem_address  <= '0;
                            loaded_count <= '0;
                            accepted     <= '0;
                            len_reg      <= len_clamped;
                            load_busy    <= 1'b1;
`ifdef LOADER_VERIFY_EN
                            verify_err   <= 1'b0;
`endif
                            if (len_clamped == 9'd0) begin
                                state     <= S_DONE;
                                load_done <= 1'b1;
                            end else begin
                                state <= S_POP;
                            end
                        end
                    end
                    S_POP: begin
                        if (pop) begin
                            mem_wdata  <= fifo_mem[rd_ptr];
                            cs_control <= 1'b1;
                            we_control <= 1'b1;
                            state      <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        loaded_count <= loaded_count + 9'd1;
                        we_control   <= 1'b0;
`ifdef LOADER_VERIFY_EN
                        // The address is held so the readback hits the word just written.
                        oe_control <= 1'b1;
                        state      <= S_RD;
`else
                        cs_control  <= 1'b0;
                        mem_address <= next_addr;
                        if ((loaded_count + 9'd1) == len_reg) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                        end else begin
                            state <= S_POP;
                        end
`endif
                    end
`ifdef LOADER_VERIFY_EN
                    S_RD: begin
                        cs_control <= 1'b0;
                        oe_control <= 1'b0;
                        state      <= S_CMP;
                    end
                    S_CMP: begin
                        if (mem_rdata != mem_wdata) verify_err <= 1'b1;
                        mem_address <= next_addr;
                        if (loaded_count == len_reg) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                        end else begin
                            state <= S_POP;
                        end
                    end
`endif
                    S_DONE: begin
                        load_busy <= 1'b0;
                        state     <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_training_mem_loader.sv
// tb_training_mem_loader: directed bench for training_mem_loader with a behavioural
// training_data_mem model. When LOADER_VERIFY_EN is defined, the readback-corruption
// scenario is also compiled in.
module tb_training_mem_loader;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        load_start;
    logic [8:0]  load_len;
    logic        load_abort;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_label;
    logic [7:0]  mem_address;
    logic [32:0] mem_wdata;
    logic [32:0] mem_rdata;
    logic        cs_control;
    logic        we_control;
    logic        oe_control;
    logic        load_busy;
    logic        load_done;
    logic [8:0]  loaded_count;
    logic        verify_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [32:0] tb_mem [256];
    logic [31:0] sd [256];
    logic        sl [256];

    int   wr_count   = 0;
    int   wr_base    = 0;
    int   seq_err    = 0;
    int   done_cnt   = 0;
    int   hs_count   = 0;
    logic [7:0] last_wr_addr = 8'h00;
    logic corrupt    = 1'b0;

    int got;
    int stalls;
    int done_base;
    int hs_base;
    int errs;

    training_mem_loader #(.FIFO_DEPTH(4), .MAX_SAMPLES(256)) dut (
        .CLK          (CLK),
        .RESETn       (RESETn),
        .load_start   (load_start),
        .load_len     (load_len),
        .load_abort   (load_abort),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_label     (in_label),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .cs_control   (cs_control),
        .we_control   (we_control),
        .oe_control   (oe_control),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .loaded_count (loaded_count),
        .verify_err   (verify_err)
    );

    always #5 CLK = ~CLK;

    // Memory model: synchronous write, registered read, and a write-order tracker
    always @(posedge CLK) begin
        if (cs_control && we_control) begin
            tb_mem[mem_address] <= mem_wdata;
            if (mem_address != 8'(wr_count - wr_base)) seq_err <= seq_err + 1;
            last_wr_addr <= mem_address;
            wr_count     <= wr_count + 1;
        end
        if (cs_control && oe_control && !we_control)
            mem_rdata <= tb_mem[mem_address] ^
                         ((corrupt && mem_address == 8'd1) ? 33'h1_0000_0000 : 33'h0);
    end

    // Handshake and done-pulse counters
    always @(posedge CLK) if (in_valid && in_ready) hs_count <= hs_count + 1;
    always @(negedge CLK) if (load_done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fill(input logic [31:0] seed);
        for (int i = 0; i < 256; i++) begin
            sd[i] = seed ^ (i * 32'h0101_0103);
            sl[i] = (i % 2 == 1) ^ seed[0];
        end
    endtask

    task automatic start_load(input logic [8:0] len);
        @(posedge CLK); #1;
        load_start = 1'b1;
        load_len   = len;
        @(posedge CLK); #1;
        load_start = 1'b0;
    endtask

    task automatic stream(input int n, input int budget, output int acc_n, output int stall_n);
        int   c;
        logic acc;
        acc_n = 0; stall_n = 0; c = 0;
        while (acc_n < n && c < budget) begin
            in_valid = 1'b1;
            in_data  = sd[acc_n];
            in_label = sl[acc_n];
            @(negedge CLK);
            acc = in_ready;
            if (!acc) stall_n++;
            @(posedge CLK); #1;
            if (acc) acc_n++;
            c++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge CLK);
            if (!load_busy) break;
        end
    endtask

    task automatic begin_session();
        wr_base   = wr_count;
        done_base = done_cnt;
        hs_base   = hs_count;
    endtask

    initial begin
        RESETn = 1'b0; load_start = 1'b0; load_len = '0; load_abort = 1'b0;
        in_valid = 1'b0; in_data = '0; in_label = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_in_ready", in_ready, 0);
        check("rst_cs_we_oe", {cs_control, we_control, oe_control}, 0);
        check("rst_busy_done", {load_busy, load_done}, 0);
        check("rst_count", loaded_count, 0);
        check("rst_addr", mem_address, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_verify_err", verify_err, 0);
        RESETn = 1'b1;

        // len=3 with the listed words streamed back-to-back
        sd[0] = 32'h0102_0304; sl[0] = 1'b1;
        sd[1] = 32'hFF80_007F; sl[1] = 1'b0;
        sd[2] = 32'h0000_0000; sl[2] = 1'b1;
        begin_session();
        start_load(9'd3);
        check("t1_busy", load_busy, 1);
        stream(3, 50, got, stalls);
        check("t1_accepted", got, 3);
        wait_idle(50);
        check("t1_mem0", tb_mem[0], 33'h1_0102_0304);
        check("t1_mem1", tb_mem[1], 33'h0_FF80_007F);
        check("t1_mem2", tb_mem[2], 33'h1_0000_0000);
        check("t1_done_pulses", done_cnt - done_base, 1);
        check("t1_count", loaded_count, 3);
        check("t1_busy_end", load_busy, 0);
        check("t1_strobes_idle", {cs_control, we_control, oe_control}, 0);

        // len=256 with continuous valid, then a 257th word is offered
        fill(32'hA5C3_0F00);
        begin_session();
        start_load(9'd256);
        stream(256, 3000, got, stalls);
        check("t2_accepted", got, 256);
        check("t2_fifo_full_stall_seen", stalls > 0, 1);
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_label = 1'b1;
        @(negedge CLK);
        check("t2_257th_ready", in_ready, 0);
        check("t2_busy_pending", load_busy, 1);
        wait_idle(100);
        in_valid = 1'b0;
        check("t2_handshakes", hs_count - hs_base, 256);
        check("t2_count", loaded_count, 256);
        check("t2_writes", wr_count - wr_base, 256);
        check("t2_last_addr", last_wr_addr, 8'hFF);
        check("t2_addr_no_wrap", mem_address, 8'hFF);
        check("t2_done_pulses", done_cnt - done_base, 1);
        errs = 0;
        for (int i = 0; i < 256; i++)
            if (tb_mem[i] !== {sl[i], sd[i]}) errs++;
        check("t2_mem_order", errs, 0);

        // Abort after 5 writes of len=10; a second load_start while busy is ignored
        fill(32'h3C3C_1201);
        begin_session();
        start_load(9'd10);
        start_load(9'd2);
        stream(6, 200, got, stalls);
        check("t3_accepted", got, 6);
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (wr_count - wr_base >= 5) break;
        end
        check("t3_writes_before_abort", wr_count - wr_base, 5);
        load_abort = 1'b1;
        @(posedge CLK); #1;
        load_abort = 1'b0;
        @(negedge CLK);
        check("t3_busy", load_busy, 0);
        check("t3_count", loaded_count, 5);
        check("t3_ready", in_ready, 0);
        check("t3_strobes", {cs_control, we_control, oe_control}, 0);
        repeat (4) @(negedge CLK);
        check("t3_writes_after", wr_count - wr_base, 5);
        check("t3_no_done", done_cnt - done_base, 0);

        fill(32'h7711_4402);
        begin_session();
        start_load(9'd2);
        stream(2, 50, got, stalls);
        wait_idle(50);
        check("t3_restart_mem0", tb_mem[0], {sl[0], sd[0]});
        check("t3_restart_mem1", tb_mem[1], {sl[1], sd[1]});
        check("t3_restart_count", loaded_count, 2);
        check("t3_restart_done", done_cnt - done_base, 1);

        // Asynchronous reset in the middle of a session
        fill(32'h0BAD_F00D);
        begin_session();
        start_load(9'd10);
        stream(4, 50, got, stalls);
        @(negedge CLK);
        check("t4_busy_before", load_busy, 1);
        #2 RESETn = 1'b0;
        #1;
        check("t4_rst_busy", load_busy, 0);
        check("t4_rst_count_addr", {loaded_count, mem_address}, 0);
        check("t4_rst_strobes", {cs_control, we_control, oe_control, in_ready}, 0);
        check("t4_rst_wdata", mem_wdata, 0);
        @(negedge CLK);
        RESETn = 1'b1;
        fill(32'h6502_8086);
        begin_session();
        start_load(9'd2);
        stream(2, 50, got, stalls);
        wait_idle(50);
        check("t4_mem0", tb_mem[0], {sl[0], sd[0]});
        check("t4_mem1", tb_mem[1], {sl[1], sd[1]});
        check("t4_count", loaded_count, 2);
        check("t4_done", done_cnt - done_base, 1);

        // Zero-length load
        begin_session();
        start_load(9'd0);
        @(negedge CLK);
        check("t5_done_pulse", load_done, 1);
        check("t5_busy", load_busy, 1);
        check("t5_count", loaded_count, 0);
        @(negedge CLK);
        check("t5_done_end", {load_done, load_busy}, 0);
        check("t5_no_writes", wr_count - wr_base, 0);

`ifdef LOADER_VERIFY_EN
        // Readback corrupted at address 1
        fill(32'h1357_9BDF);
        corrupt = 1'b1;
        begin_session();
        start_load(9'd3);
        stream(3, 100, got, stalls);
        wait_idle(100);
        corrupt = 1'b0;
        check("t6_verify_err", verify_err, 1);
        check("t6_count", loaded_count, 3);
        start_load(9'd2);
        @(negedge CLK);
        check("t6_err_cleared", verify_err, 0);
        stream(2, 100, got, stalls);
        wait_idle(100);
        check("t6_clean_err", verify_err, 0);
`endif

        check("write_sequence", seq_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
